mem_access_arb: RTL and testbench
=================================

Name: mem_access_arb

Overview:
- Two-requester arbiter and sequencer in front of the banked memory/register address space (register, input, weight, feature banks, selected by addr[11:8]).
- Shares one downstream memory port between the host (AXI4-Lite bridge) and the convolution engine.
- Grants round-robin, issues one access at a time, waits for read completion with a timeout, and routes read data back to the winning requester.
- Sits between axi4l bridge/conv engine and the bank address decoder.

Parameters:
ADDR_WIDTH, 12, byte address width of all address ports
DATA_WIDTH, 32, data width of all data ports
TIMEOUT, 16, max cycles waited for m_valid after a read issue (>=2)
ERR_DATA, 32'h0, rdata returned on a timed-out read

Ports:
clk_a  in  1  clock
arstz_aq  in  1  reset, synchronous, active-low
h_req  in  1  host request, held until h_gnt
h_we  in  1  host write enable (1=write, 0=read)
h_addr  in  ADDR_WIDTH  host address
h_din  in  DATA_WIDTH  host write data
h_gnt  out  1  host grant pulse (1 cycle)
h_rdata  out  DATA_WIDTH  host read data
h_rvalid  out  1  host read data valid pulse
e_req, e_we, e_addr, e_din, e_gnt, e_rdata, e_rvalid  same as h_* for the conv engine
m_en  out  1  downstream access strobe
m_we  out  1  downstream write enable
m_addr  out  ADDR_WIDTH  downstream address
m_din  out  DATA_WIDTH  downstream write data
m_dout  in  DATA_WIDTH  downstream read data
m_valid  in  1  downstream read data valid
busy  out  1  access in progress (state != IDLE)
timeout_err  out  1  pulse on read timeout
err_cnt  out  8  saturating count of timeouts

Behaviour:
- Reset (arstz_aq=0 at posedge): all outputs 0, state IDLE, last-grant pointer = ENGINE (host wins the first tie), timeout counter 0, err_cnt 0.
- Mid-operation reset aborts any pending read: no rvalid is ever produced for it.
- States: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - Sample h_req/e_req.
  - One requester active: select it.
  - Both active: select the one not granted last, then update the pointer.
  - Latch we/addr/din of the winner. Next state ISSUE.
- ISSUE (exactly 1 cycle):
  - m_en=1; m_we/m_addr/m_din are the latched values; winner's gnt=1.
  - Requester may change or drop req from the next cycle.
  - Write: return to IDLE; write completes here.
  - Read: go to RD_WAIT; timeout counter cleared.
- RD_WAIT:
  - m_en=0, counter increments each cycle.
  - On m_valid=1: capture m_dout into the winner's rdata; rvalid=1 on the next cycle; return to IDLE.
  - If the counter reaches TIMEOUT-1 without m_valid: rdata=ERR_DATA, rvalid=1 next cycle, timeout_err=1 the same cycle as rvalid, err_cnt+1 (saturates at 255); return to IDLE.
  - m_valid on the timeout cycle counts as success.
- Registered outputs:
  - m_* are 0 outside ISSUE.
  - gnt/rvalid/timeout_err are single-cycle pulses.
  - rdata holds its value until the next read for that requester.
  - The non-winner's rdata/rvalid are untouched.
- Latency:
  - req high in IDLE at cycle N gives gnt+m_en at N+1.
  - A write frees the arbiter at N+2.
  - A read with m_valid at cycle K gives rvalid at K+1 and IDLE at K+1.
  - A back-to-back request can issue at K+2.
- m_valid outside RD_WAIT is ignored.
- A requester's req held high after its gnt is treated as a new request.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- Address is passed unmodified; bank decode is downstream. Out-of-range banks (addr[11:8]>3) yield no m_valid → timeout path.
- busy = (state != IDLE).

Test Plan:
- Reset then host write h_addr=12'h104, h_din=32'hA5A5_0001 → m_en/m_we=1, m_addr=12'h104, m_din=32'hA5A5_0001 and h_gnt=1 one cycle after h_req; e_gnt stays 0; busy low 2 cycles after req.
- Engine read e_addr=12'h200, downstream m_valid 2 cycles after m_en with m_dout=32'h1234_5678 → e_rvalid=1 one cycle later, e_rdata=32'h1234_5678; h_rvalid stays 0.
- h_req and e_req held high simultaneously for 4 grants after reset → grant order host, engine, host, engine.
- Host read to m_addr=12'h500 (unmapped bank, no m_valid), TIMEOUT=16 → h_rvalid=1, h_rdata=32'h0, timeout_err pulse, err_cnt=1; arbiter returns to IDLE and grants the next request.
- Engine read in RD_WAIT, arstz_aq=0 for 1 cycle before m_valid → all outputs 0, no e_rvalid even when the late m_valid arrives, state IDLE, err_cnt=0.
- m_valid pulsed while IDLE with m_dout=32'hFFFF_FFFF → no rvalid on either side; h_rdata/e_rdata unchanged.

Source files
------------

// File: rtl/mem_access_arb.sv
// Two-requester arbiter/sequencer sharing one downstream memory port between
// the host bridge and the convolution engine. Round-robin grant, one access in
// flight, read completion with timeout, read data routed to the winner.
module mem_access_arb #(
    parameter int unsigned           ADDR_WIDTH = 12,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           TIMEOUT    = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = '0
) (
    input  logic                  clk_a,
    input  logic                  arstz_aq,

    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_din,
    output logic                  h_gnt,
    output logic [DATA_WIDTH-1:0] h_rdata,
    output logic                  h_rvalid,

    input  logic                  e_req,
    input  logic                  e_we,
    input  logic [ADDR_WIDTH-1:0] e_addr,
    input  logic [DATA_WIDTH-1:0] e_din,
    output logic                  e_gnt,
    output logic [DATA_WIDTH-1:0] e_rdata,
    output logic                  e_rvalid,

    output logic                  m_en,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_din,
    input  logic [DATA_WIDTH-1:0] m_dout,
    input  logic                  m_valid,

    output logic                  busy,
    output logic                  timeout_err,
    output logic [7:0]            err_cnt
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT
    } state_t;

    typedef enum logic {
        SRC_HOST,
        SRC_ENG
    } src_t;

    state_t           state;
    src_t             last_src;
    src_t             owner;
    logic [CNT_W-1:0] tcnt;

    logic             pick_eng;
    logic [DATA_WIDTH-1:0] rd_word;

    // Winner selection for the IDLE cycle and the word delivered on read completion
    always_comb begin
        pick_eng = 1'b0;
        if (e_req && (!h_req || (last_src == SRC_HOST))) begin
            pick_eng = 1'b1;
        end
        rd_word = ERR_DATA;
        if (m_valid) begin
            rd_word = m_dout;
        end
    end

    // Access sequencer with registered outputs; the m_* registers double as the
    // latched copy of the winner's request for the single ISSUE cycle
    always_ff @(posedge clk_a) begin
        if (!arstz_aq) begin
            state       <= IDLE;
            last_src    <= SRC_ENG;
            owner       <= SRC_HOST;
            tcnt        <= '0;
            h_gnt       <= 1'b0;
            h_rdata     <= '0;
            h_rvalid    <= 1'b0;
            e_gnt       <= 1'b0;
            e_rdata     <= '0;
            e_rvalid    <= 1'b0;
            m_en        <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_din       <= '0;
            timeout_err <= 1'b0;
            err_cnt     <= '0;
        end else begin
            h_gnt       <= 1'b0;
            e_gnt       <= 1'b0;
            h_rvalid    <= 1'b0;
            e_rvalid    <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (h_req || e_req) begin
                        state <= ISSUE;
                        m_en  <= 1'b1;
                        if (pick_eng) begin
                            owner    <= SRC_ENG;
                            last_src <= SRC_ENG;
                            m_we     <= e_we;
                            m_addr   <= e_addr;
                            m_din    <= e_din;
                            e_gnt    <= 1'b1;
                        end else begin
                            owner    <= SRC_HOST;
                            last_src <= SRC_HOST;
                            m_we     <= h_we;
                            m_addr   <= h_addr;
                            m_din    <= h_din;
                            h_gnt    <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    m_en   <= 1'b0;
                    m_we   <= 1'b0;
                    m_addr <= '0;
                    m_din  <= '0;
                    if (m_we) begin
                        state <= IDLE;
                    end else begin
                        state <= RD_WAIT;
                        tcnt  <= '0;
                    end
                end

                RD_WAIT: begin
                    if (m_valid || (tcnt == CNT_LAST)) begin
                        state <= IDLE;
                        if (owner == SRC_ENG) begin
                            e_rdata  <= rd_word;
                            e_rvalid <= 1'b1;
                        end else begin
                            h_rdata  <= rd_word;
                            h_rvalid <= 1'b1;
                        end
                        if (!m_valid) begin
                            timeout_err <= 1'b1;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Busy whenever an access is being issued or awaited
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_access_arb.sv
// Randomized scoreboard bench for mem_access_arb: the bench plays both
// requesters and the downstream memory, predicts every grant and read
// completion from the arbitration rules, and checks the DUT against it.
module tb_mem_access_arb;

    localparam int TO  = 16;
    localparam int BIG = 32'h3fff_ffff;

    logic        clk;
    logic        arstz_aq;
    logic        h_req, h_we, e_req, e_we;
    logic [11:0] h_addr, e_addr;
    logic [31:0] h_din, e_din;
    logic        h_gnt, h_rvalid, e_gnt, e_rvalid;
    logic [31:0] h_rdata, e_rdata;
    logic        m_en, m_we, m_valid;
    logic [11:0] m_addr;
    logic [31:0] m_din, m_dout;
    logic        busy, timeout_err;
    logic [7:0]  err_cnt;

    mem_access_arb #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(32),
        .TIMEOUT   (TO),
        .ERR_DATA  (32'h0)
    ) dut (
        .clk_a      (clk),
        .arstz_aq   (arstz_aq),
        .h_req      (h_req),
        .h_we       (h_we),
        .h_addr     (h_addr),
        .h_din      (h_din),
        .h_gnt      (h_gnt),
        .h_rdata    (h_rdata),
        .h_rvalid   (h_rvalid),
        .e_req      (e_req),
        .e_we       (e_we),
        .e_addr     (e_addr),
        .e_din      (e_din),
        .e_gnt      (e_gnt),
        .e_rdata    (e_rdata),
        .e_rvalid   (e_rvalid),
        .m_en       (m_en),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_din      (m_din),
        .m_dout     (m_dout),
        .m_valid    (m_valid),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- controls written by the stimulus process ----------
    int probe       = 0;
    int force_delay = 0;
    bit stray_en    = 0;
    bit stray_force = 0;
    int drv_to      = 0;

    // ---------------- reference model state -----------------------------
    typedef struct {
        logic [31:0] data;
        bit          tof;
        int          due;
    } rd_t;

    rd_t         hq[$];
    rd_t         eq[$];
    rd_t         ent;
    bit          glog[$];
    int          glog_mark = 0;
    logic [31:0] mem [logic [11:0]];

    int          n_chk = 0;
    int          n_pass = 0;
    bit          chk_en = 0;
    int          idle_from = 0;
    int          exp_issue_cyc = -1;
    bit          exp_who, exp_we;
    logic [11:0] exp_addr;
    logic [31:0] exp_din;
    bit          last_who = 1;
    int          exp_err = 0;
    bit          exp_to;
    logic [31:0] exp_hrd = '0, exp_erd = '0;
    int          resp_cyc = -1;
    logic [31:0] resp_data = '0;
    bit          stray_ok = 0;
    int          c, d;
    bit          iss, w;
    logic [3:0]  seq;

    function automatic logic [31:0] mem_rd(input logic [11:0] a);
        if (mem.exists(a)) return mem[a];
        return {a, 4'h3, ~a, 4'hC};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Monitor + reference model, evaluated mid-cycle
    always @(negedge clk) begin
        c = cyc;
        exp_to = 0;
        if (chk_en) begin
            iss = (c == exp_issue_cyc);
            if (iss || m_en || h_gnt || e_gnt)
                check("issue", {m_en, m_we, m_addr, m_din, h_gnt, e_gnt},
                      iss ? {1'b1, exp_we, exp_addr, exp_din, !exp_who, exp_who} : '0);
            if (h_gnt) glog.push_back(0);
            if (e_gnt) glog.push_back(1);

            if (h_rvalid) begin
                if (hq.size() == 0) check("h_rvalid_unexpected", 1, 0);
                else begin
                    ent = hq.pop_front();
                    check("h_read", {32'(c), h_rdata, timeout_err}, {32'(ent.due), ent.data, ent.tof});
                    exp_hrd = ent.data;
                    if (ent.tof) begin exp_to = 1; if (exp_err < 255) exp_err++; end
                end
            end else if (hq.size() > 0 && hq[0].due < c) begin
                ent = hq.pop_front();
                check("h_read_missing", 0, 1);
                exp_hrd = ent.data;
                if (ent.tof && exp_err < 255) exp_err++;
            end

            if (e_rvalid) begin
                if (eq.size() == 0) check("e_rvalid_unexpected", 1, 0);
                else begin
                    ent = eq.pop_front();
                    check("e_read", {32'(c), e_rdata, timeout_err}, {32'(ent.due), ent.data, ent.tof});
                    exp_erd = ent.data;
                    if (ent.tof) begin exp_to = 1; if (exp_err < 255) exp_err++; end
                end
            end else if (eq.size() > 0 && eq[0].due < c) begin
                ent = eq.pop_front();
                check("e_read_missing", 0, 1);
                exp_erd = ent.data;
                if (ent.tof && exp_err < 255) exp_err++;
            end

            check("state", {busy, timeout_err, err_cnt, h_rdata, e_rdata},
                  {c < idle_from, exp_to, 8'(exp_err), exp_hrd, exp_erd});

            if (iss) begin
                if (exp_we) begin
                    mem[exp_addr] = exp_din;
                    idle_from = c + 1;
                end else begin
                    ent.tof = 0;
                    if (exp_addr[11:8] <= 4'd3) begin
                        d = (force_delay != 0) ? force_delay : int'($urandom_range(1, TO));
                        resp_cyc  = c + d;
                        resp_data = mem_rd(exp_addr);
                        ent.data  = resp_data;
                        ent.due   = c + d + 1;
                    end else begin
                        ent.data = 32'h0;
                        ent.tof  = 1;
                        ent.due  = c + TO + 1;
                    end
                    idle_from = ent.due;
                    if (exp_who) eq.push_back(ent); else hq.push_back(ent);
                end
            end

            case (probe)
                1: check("reset_outputs",
                         {h_gnt, h_rdata, h_rvalid, e_gnt, e_rdata, e_rvalid, m_en, m_we,
                          m_addr, m_din, busy, timeout_err, err_cnt}, '0);
                2: check("eng_read_data", {e_rdata, h_rdata}, {32'h1234_5678, 32'h0});
                3: glog_mark = glog.size();
                4: begin
                    seq = 4'bxxxx;
                    for (int k = 0; k < 4; k++)
                        if (glog_mark + k < glog.size()) seq[3-k] = glog[glog_mark + k];
                    check("tie_grant_order", seq, 4'b0101);
                end
                5: check("timeout_result", {err_cnt, h_rdata}, {8'd1, 32'h0});
                9: begin
                    check("driver_grant_waits", drv_to, 0);
                    check("scoreboard_drained", hq.size() + eq.size(), 0);
                end
                default: ;
            endcase
        end

        if (!arstz_aq) begin
            chk_en        = 1;
            idle_from     = c + 1;
            exp_issue_cyc = -1;
            hq.delete();
            eq.delete();
            last_who      = 1;
            exp_err       = 0;
            exp_hrd       = '0;
            exp_erd       = '0;
        end else if (chk_en && c >= idle_from && (h_req || e_req)) begin
            w             = (h_req && e_req) ? !last_who : e_req;
            last_who      = w;
            exp_who       = w;
            exp_we        = w ? e_we : h_we;
            exp_addr      = w ? e_addr : h_addr;
            exp_din       = w ? e_din : h_din;
            exp_issue_cyc = c + 1;
            idle_from     = BIG;
        end
        stray_ok = (c + 1 >= idle_from) || (c + 1 == exp_issue_cyc);
    end

    // Downstream memory responder
    initial begin
        m_valid = 1'b0;
        m_dout  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc == resp_cyc) begin
                m_valid = 1'b1;
                m_dout  = resp_data;
            end else if (stray_ok && (stray_force || (stray_en && $urandom_range(0, 7) == 0))) begin
                m_valid = 1'b1;
                m_dout  = stray_force ? 32'hFFFF_FFFF : $urandom;
            end else begin
                m_valid = 1'b0;
                m_dout  = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- stimulus ------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic req_txn(input int who, input logic we, input logic [11:0] a,
                           input logic [31:0] dv, input bit keep);
        bit got = 0;
        int k   = 0;
        if (who == 0) begin h_we = we; h_addr = a; h_din = dv; h_req = 1'b1; end
        else          begin e_we = we; e_addr = a; e_din = dv; e_req = 1'b1; end
        while (!got && k < 400) begin
            @(negedge clk);
            got = (who == 0) ? h_gnt : e_gnt;
            k++;
        end
        if (!got) drv_to++;
        step();
        if (!keep) begin
            if (who == 0) h_req = 1'b0; else e_req = 1'b0;
        end
    endtask

    task automatic rand_stream(input int who, input int n);
        logic [11:0] a;
        int          gap;
        for (int i = 0; i < n; i++) begin
            a   = {4'($urandom_range(0, 5)), 8'($urandom)};
            gap = $urandom_range(0, 3);
            if (i == n - 1) gap = 1;
            req_txn(who, 1'($urandom_range(0, 1)), a, $urandom, gap == 0);
            idle(gap);
        end
    endtask

    initial begin
        arstz_aq = 1'b0;
        h_req = 0; h_we = 0; h_addr = '0; h_din = '0;
        e_req = 0; e_we = 0; e_addr = '0; e_din = '0;
        repeat (3) @(posedge clk);
        #1;
        arstz_aq = 1'b1;
        probe = 1; step(); probe = 0;

        req_txn(0, 1'b1, 12'h104, 32'hA5A5_0001, 0);
        idle(4);
        req_txn(0, 1'b1, 12'h200, 32'h1234_5678, 0);
        idle(3);

        force_delay = 2;
        req_txn(1, 1'b0, 12'h200, 32'h0, 0);
        idle(6);
        probe = 2; step(); probe = 0;
        force_delay = 0;

        probe = 3; step(); probe = 0;
        fork
            begin
                req_txn(0, 1'b1, 12'h010, 32'h0000_0001, 1);
                req_txn(0, 1'b1, 12'h014, 32'h0000_0002, 0);
            end
            begin
                req_txn(1, 1'b1, 12'h300, 32'h0000_0003, 1);
                req_txn(1, 1'b1, 12'h304, 32'h0000_0004, 0);
            end
        join
        idle(4);
        probe = 4; step(); probe = 0;

        req_txn(0, 1'b0, 12'h500, 32'h0, 0);
        idle(TO + 4);
        probe = 5; step(); probe = 0;
        req_txn(1, 1'b1, 12'h208, 32'hCAFE_0001, 0);
        idle(3);

        force_delay = 6;
        req_txn(1, 1'b0, 12'h204, 32'h0, 0);
        step();
        arstz_aq = 1'b0;
        step();
        arstz_aq = 1'b1;
        probe = 1; step(); probe = 0;
        idle(8);
        force_delay = 0;

        req_txn(0, 1'b0, 12'h104, 32'h0, 0);
        idle(TO + 4);
        req_txn(1, 1'b0, 12'h200, 32'h0, 0);
        idle(TO + 4);
        stray_force = 1;
        idle(12);
        stray_force = 0;

        stray_en = 1;
        fork
            rand_stream(0, 120);
            rand_stream(1, 120);
        join
        stray_en = 0;
        idle(TO + 10);
        probe = 9; step(); probe = 0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
